// File: rtl/fp_pkg.sv
// Shared definitions for the integer-to-float conversion path: rounding modes and
// compile-time width helpers.
package fp_pkg;

  typedef enum logic [2:0] {
    Rne = 3'd0,
    Rtz = 3'd1,
    Rdn = 3'd2,
    Rup = 3'd3,
    Rmm = 3'd4
  } rm_e;

  function automatic int unsigned fp_bias(int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned max_w(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lzc_param.sv
// Parametrised leading-zero counter; an all-zero input reports W.
module lzc_param #(
  parameter int unsigned W  = 64,
  localparam int unsigned CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  i_data,
  output logic [CW-1:0] o_count
);

  // Scanning upward lets the most significant set bit win.
  always_comb begin
    o_count = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (i_data[i]) begin
        o_count = CW'(W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/int_to_fp_pipe.sv
// Three-stage integer to IEEE binary converter with five rounding modes and a
// whole-pipeline valid/ready stall.
module int_to_fp_pipe
  import fp_pkg::*;
#(
  parameter int unsigned INT_W = 64,
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INT_W-1:0]       in_int,
  input  logic                   in_signed,
  input  logic [2:0]             in_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_fp,
  output logic                   out_inexact
);

  localparam int unsigned AW   = max_w(INT_W, MAN_W + 3);
  localparam int unsigned LZW  = $clog2(INT_W) + 1;
  localparam int unsigned BIAS = fp_bias(EXP_W);
  localparam int unsigned SW   = MAN_W + 1;
  localparam int unsigned EW1  = EXP_W + 1;

  if (INT_W > (32'd1 << (EXP_W - 1))) begin : g_param_check
    $error("INT_W must not exceed 2**(EXP_W-1)");
  end

  logic w_advance;
  logic r1_valid, r2_valid, r3_valid;

  assign w_advance = out_ready | ~r3_valid;
  assign in_ready  = w_advance;

  // Stage 1: sign and magnitude
  logic             w_sign;
  logic [INT_W-1:0] w_mag;
  logic             r1_sign, r1_zero;
  logic [INT_W-1:0] r1_mag;
  logic [2:0]       r1_rm;

  assign w_sign = in_signed & in_int[INT_W-1];
  assign w_mag  = w_sign ? (-in_int) : in_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_zero  <= 1'b0;
      r1_mag   <= '0;
      r1_rm    <= '0;
    end else if (w_advance) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign <= w_sign;
        r1_zero <= (in_int == '0);
        r1_mag  <= w_mag;
        r1_rm   <= in_rm;
      end
    end
  end

  // Stage 2: normalise
  logic [LZW-1:0]   w_lzc;
  logic [INT_W-1:0] w_norm;
  logic             r2_sign, r2_zero;
  logic [2:0]       r2_rm;
  logic [LZW-1:0]   r2_lzc;
  logic [INT_W-1:0] r2_norm;

  lzc_param #(
    .W (INT_W)
  ) u_lzc (
    .i_data  (r1_mag),
    .o_count (w_lzc)
  );

  assign w_norm = r1_mag << w_lzc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_zero  <= 1'b0;
      r2_rm    <= '0;
      r2_lzc   <= '0;
      r2_norm  <= '0;
    end else if (w_advance) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sign <= r1_sign;
        r2_zero <= r1_zero;
        r2_rm   <= r1_rm;
        r2_lzc  <= w_lzc;
        r2_norm <= w_norm;
      end
    end
  end

  // Stage 3: round and pack
  logic [AW-1:0]          w_ext, w_rest;
  logic [SW-1:0]          w_sig;
  logic                   w_g, w_r, w_s, w_inc, w_carry;
  logic [SW:0]            w_sum;
  logic [EXP_W:0]         w_exp, w_exp_fin;
  logic [MAN_W-1:0]       w_frac;
  logic [EXP_W+MAN_W:0]   w_fp;
  logic                   w_inexact;
  logic                   w_unused_bits;
  logic [EXP_W+MAN_W:0]   r3_fp;
  logic                   r3_inexact;

  // Normalised value sits MSB-aligned; padding goes below it.
  assign w_ext  = AW'(r2_norm) << (AW - INT_W);
  assign w_sig  = w_ext[AW-1 -: SW];
  assign w_g    = w_ext[AW-1-SW];
  assign w_r    = w_ext[AW-2-SW];
  assign w_rest = w_ext << (SW + 2);
  assign w_s    = |w_rest;

  always_comb begin
    w_inc = 1'b0;
    case (r2_rm)
      Rtz:     w_inc = 1'b0;
      Rdn:     w_inc = r2_sign & (w_g | w_r | w_s);
      Rup:     w_inc = ~r2_sign & (w_g | w_r | w_s);
      Rmm:     w_inc = w_g;
      default: w_inc = w_g & (w_sig[0] | w_r | w_s);
    endcase
  end

  assign w_sum     = {1'b0, w_sig} + {{SW{1'b0}}, w_inc};
  assign w_carry   = w_sum[SW];
  assign w_exp     = EW1'(BIAS + INT_W - 1) - EW1'(r2_lzc);
  assign w_exp_fin = w_exp + {{EXP_W{1'b0}}, w_carry};
  assign w_frac    = w_carry ? '0 : w_sum[MAN_W-1:0];
  assign w_fp      = r2_zero ? '0 : {r2_sign, w_exp_fin[EXP_W-1:0], w_frac};
  assign w_inexact = ~r2_zero & (w_g | w_r | w_s);

  // Exponent headroom bit and the hidden bit never reach the packed result.
  assign w_unused_bits = ^{w_exp_fin[EXP_W], w_sum[MAN_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_valid   <= 1'b0;
      r3_fp      <= '0;
      r3_inexact <= 1'b0;
    end else if (w_advance) begin
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r3_fp      <= w_fp;
        r3_inexact <= w_inexact;
      end
    end
  end

  assign out_valid   = r3_valid;
  assign out_fp      = r3_fp;
  assign out_inexact = r3_inexact;

endmodule
